// File: rtl/ariane_pkg.sv
// Shared core types used by the CV-X-IF writeback buffer.
package ariane_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned TRANS_ID_BITS  = 3;
  localparam int unsigned CVXIF_WB_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               ex;
    logic                     we;
  } cvxif_wb_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with flush; head is presented combinationally on data_o.
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] usage_o,
  input  dtype             data_i,
  input  logic             push_i,
  output dtype             data_o,
  input  logic             pop_i
);

  dtype             mem_q [DEPTH];
  dtype             mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer, count and storage next-state; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cvxif_wb_buffer.sv
// Result buffer between the CV-X-IF functional unit and the scoreboard
// writeback port: issue credits, in-order result FIFO, flush discard tracking.
module cvxif_wb_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH         = CVXIF_WB_DEPTH,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_fire_i,
  output logic                     issue_ready_o,
  input  logic                     in_valid_i,
  input  logic [TRANS_ID_BITS-1:0] in_trans_id_i,
  input  logic [XLEN-1:0]          in_result_i,
  input  exception_t               in_exception_i,
  input  logic                     in_we_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output exception_t               wb_exception_o,
  output logic                     wb_we_o,
  output logic [CW-1:0]            inflight_o
);

  // Counters hold up to DEPTH+1 (a fire landing in a flush cycle); sums get one more bit.
  localparam int unsigned W  = $clog2(DEPTH + 2);
  localparam int unsigned SW = W + 1;

  logic [W-1:0]    pending_q, pending_d;
  logic [W-1:0]    discard_q, discard_d;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_usage;
  cvxif_wb_entry_t push_entry, head_entry;
  logic            push, pop, no_discard, accept_dec;
  logic [SW-1:0]   busy_sum;

  assign no_discard = (discard_q == '0);
  assign accept_dec = in_valid_i && no_discard;
  assign push       = accept_dec && !flush_i;
  assign pop        = wb_valid_o && wb_ready_i;
  assign busy_sum   = {1'b0, pending_q} + SW'(fifo_usage);

  assign issue_ready_o = (busy_sum < SW'(DEPTH)) && no_discard && !flush_i;
  assign inflight_o    = CW'(busy_sum);

  // Pack the incoming result into a FIFO entry.
  always_comb begin
    push_entry.trans_id = in_trans_id_i;
    push_entry.result   = in_result_i;
    push_entry.ex       = in_exception_i;
    push_entry.we       = in_we_i;
  end

  fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (cvxif_wb_entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (flush_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (push_entry),
    .push_i  (push),
    .data_o  (head_entry),
    .pop_i   (pop)
  );

  // Head toward writeback, zeroed when nothing is buffered.
  always_comb begin
    wb_valid_o     = !fifo_empty;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    wb_we_o        = 1'b0;
    if (!fifo_empty) begin
      wb_trans_id_o  = head_entry.trans_id;
      wb_result_o    = head_entry.result;
      wb_exception_o = head_entry.ex;
      wb_we_o        = head_entry.we;
    end
  end

  // Pending/discard bookkeeping; on flush every outstanding instr becomes a discard,
  // and a result returning in the flush cycle is one of them.
  always_comb begin
    logic [SW-1:0] dsum;
    logic [SW-1:0] psum;
    pending_d = pending_q;
    discard_d = discard_q;
    dsum      = {1'b0, discard_q} + {1'b0, pending_q} + SW'(issue_fire_i);
    psum      = {1'b0, pending_q} + SW'(issue_fire_i);
    if (flush_i) begin
      pending_d = '0;
      discard_d = (dsum >= SW'(in_valid_i)) ? W'(dsum - SW'(in_valid_i)) : '0;
    end else begin
      pending_d = (psum >= SW'(accept_dec)) ? W'(psum - SW'(accept_dec)) : '0;
      if (in_valid_i && !no_discard) begin
        discard_d = discard_q - 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      discard_q <= '0;
    end else begin
      pending_q <= pending_d;
      discard_q <= discard_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));

  a_no_orphan_result : assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && no_discard && (pending_q == '0) && !issue_fire_i));

endmodule

// File: tb/tb_cvxif_wb_buffer.sv
// Randomized and directed bench for cvxif_wb_buffer against an
// instruction-level model: each issued instr is tracked alive or dead.
module tb_cvxif_wb_buffer;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush_i, issue_fire_i, issue_ready_o;
  logic                     in_valid_i, in_we_i;
  logic [TRANS_ID_BITS-1:0] in_trans_id_i;
  logic [XLEN-1:0]          in_result_i;
  exception_t               in_exception_i;
  logic                     wb_valid_o, wb_ready_i, wb_we_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [XLEN-1:0]          wb_result_o;
  exception_t               wb_exception_o;
  logic [CW-1:0]            inflight_o;

  cvxif_wb_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(TRANS_ID_BITS)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
    .issue_fire_i(issue_fire_i), .issue_ready_o(issue_ready_o),
    .in_valid_i(in_valid_i), .in_trans_id_i(in_trans_id_i),
    .in_result_i(in_result_i), .in_exception_i(in_exception_i), .in_we_i(in_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_exception_o(wb_exception_o), .wb_we_o(wb_we_o), .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
    exception_t               exc;
    logic                     we;
    bit                       alive;
  } instr_t;

  instr_t          cop_q[$];  // issued, result not yet returned by the coprocessor
  cvxif_wb_entry_t wb_q[$];   // results waiting for writeback

  logic [TRANS_ID_BITS-1:0] nxt_id;
  logic [XLEN-1:0]          nxt_data;
  exception_t               nxt_exc;
  logic                     nxt_we;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int alive_cnt();
    int n = 0;
    foreach (cop_q[i]) if (cop_q[i].alive) n++;
    return n;
  endfunction

  function automatic int dead_cnt();
    return cop_q.size() - alive_cnt();
  endfunction

  function automatic bit credit_ok();
    return (alive_cnt() + wb_q.size() < DEPTH) && (dead_cnt() == 0);
  endfunction

  function automatic void new_nxt();
    nxt_id        = TRANS_ID_BITS'($urandom);
    nxt_data      = {$urandom, $urandom};
    nxt_exc.cause = {$urandom, $urandom};
    nxt_exc.tval  = {$urandom, $urandom};
    nxt_exc.valid = 1'($urandom);
    nxt_we        = 1'($urandom);
  endfunction

  task automatic check_outputs(input bit flush);
    cvxif_wb_entry_t h;
    h = '0;
    if (wb_q.size() != 0) h = wb_q[0];
    check("issue_ready", issue_ready_o, credit_ok() && !flush);
    check("wb_valid", wb_valid_o, wb_q.size() != 0);
    check("inflight", inflight_o, alive_cnt() + wb_q.size());
    check("wb_trans_id", wb_trans_id_o, h.trans_id);
    check("wb_result", wb_result_o, h.result);
    check("wb_ex_cause", wb_exception_o.cause, h.ex.cause);
    check("wb_ex_tval", wb_exception_o.tval, h.ex.tval);
    check("wb_ex_valid", wb_exception_o.valid, h.ex.valid);
    check("wb_we", wb_we_o, h.we);
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance the model past the edge.
  task automatic step(input bit fire, input bit ret, input bit flush, input bit wbr);
    instr_t          ni, head;
    cvxif_wb_entry_t e;
    bit              have;
    @(negedge clk);
    issue_fire_i = fire;
    flush_i      = flush;
    wb_ready_i   = wbr;
    in_valid_i   = 1'b0;
    #1;
    check_outputs(flush);
    if (fire) begin
      ni.id = nxt_id; ni.data = nxt_data; ni.exc = nxt_exc; ni.we = nxt_we; ni.alive = 1'b1;
      cop_q.push_back(ni);
    end
    have = ret && (cop_q.size() != 0);
    in_valid_i      = have;
    in_trans_id_i   = TRANS_ID_BITS'($urandom);
    in_result_i     = {$urandom, $urandom};
    in_exception_i  = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
    in_we_i         = 1'($urandom);
    if (have) begin
      head = cop_q.pop_front();
      in_trans_id_i  = head.id;
      in_result_i    = head.data;
      in_exception_i = head.exc;
      in_we_i        = head.we;
    end
    if (flush) begin
      wb_q.delete();
      foreach (cop_q[i]) cop_q[i].alive = 1'b0;
    end else begin
      if (wbr && wb_q.size() != 0) void'(wb_q.pop_front());
      if (have && head.alive) begin
        e.trans_id = head.id; e.result = head.data; e.ex = head.exc; e.we = head.we;
        wb_q.push_back(e);
      end
    end
    new_nxt();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (cop_q.size() != 0 || wb_q.size() != 0); i++) step(0, 1, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; flush_i = 0; issue_fire_i = 0; in_valid_i = 0; wb_ready_i = 0;
    in_trans_id_i = '0; in_result_i = '0; in_exception_i = '0; in_we_i = 0;
    new_nxt();
    repeat (2) @(negedge clk);
    #1 check_outputs(0);
    rst = 1'b0;

    // 1: single accepted offload, result 3 cycles later
    nxt_id = 5; nxt_data = 64'hDEAD;
    step(1, 0, 0, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // 2: fill credits with writeback stalled, then release
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    drain();

    // 3: rejected offload, same-cycle illegal-instruction result
    nxt_exc.cause = ILLEGAL_INSTR; nxt_exc.tval = 64'h0000_000B; nxt_exc.valid = 1'b1;
    step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // 4: flush with one buffered and two pending
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    drain();

    // 5: flush coinciding with issue and a returning result, one pending
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    drain();

    // 6: async reset with two buffered and one pending
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    @(negedge clk);
    issue_fire_i = 0; in_valid_i = 0; flush_i = 0; wb_ready_i = 0;
    #2 rst = 1'b1;
    cop_q.delete(); wb_q.delete();
    #1 check_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bit fl, fi;
      fl = ($urandom_range(0, 19) == 0);
      fi = credit_ok() && (fl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1));
      step(fi, $urandom_range(0, 2) != 0, fl, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
